// File: rtl/pd_pkg.sv
// Shared types and constants for the pd header assembler and its helpers.
package pd_pkg;

  typedef enum logic [1:0] {PD_IDLE, PD_LOAD, PD_HOLD} pd_asm_state_t;

  localparam int PD_WORD_W    = 32;
  localparam int PD_HDR_WORDS = 20;
  localparam int PD_C1_WORDS  = 16;
  localparam int PD_C1_BITS   = 512;
  localparam int PD_C2_BITS   = 128;
  localparam int PD_NONCE_IDX = 19;
  localparam int PD_CNT_W     = 5;

endpackage

// File: rtl/pd_word_counter.sv
// Word counter for header assembly: increments on accept, synchronous clear,
// saturates at MAX_COUNT and flags the slot holding the final header word.
module pd_word_counter #(
  parameter int CNT_W     = 5,
  parameter int MAX_COUNT = 20,
  parameter int LAST_IDX  = 19
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_at_last
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CNT_W'(MAX_COUNT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_at_last = (r_count == CNT_W'(LAST_IDX));

endmodule

// File: rtl/pd_header_assembler.sv
// Collects a block header as a stream of words and presents it as two
// fixed-width chunks, held stable (with in-place nonce rewrite) until released.
module pd_header_assembler
  import pd_pkg::*;
#(
  parameter int WORD_W    = PD_WORD_W,
  parameter int HDR_WORDS = PD_HDR_WORDS,
  parameter int C1_WORDS  = PD_C1_WORDS
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                clear,
  input  logic [WORD_W-1:0]                   word_in,
  input  logic                                word_valid,
  output logic                                word_ready,
  input  logic                                nonce_wr,
  input  logic [WORD_W-1:0]                   nonce_in,
  input  logic                                chunks_taken,
  output logic [C1_WORDS*WORD_W-1:0]          chunk_1,
  output logic [(HDR_WORDS-C1_WORDS)*WORD_W-1:0] chunk_2,
  output logic                                chunks_valid,
  output logic [PD_CNT_W-1:0]                 word_count
);

  localparam int C1_BITS   = C1_WORDS * WORD_W;
  localparam int C2_BITS   = (HDR_WORDS - C1_WORDS) * WORD_W;
  localparam int NONCE_IDX = HDR_WORDS - 1;

  pd_asm_state_t      r_state;
  logic               r_valid;
  logic [PD_CNT_W-1:0] w_count;
  logic               w_at_last;
  logic               w_hold;
  logic               w_accept;
  logic               w_nonce_wr;
  logic               w_cnt_clr;
  logic [HDR_WORDS-1:0] w_slot_en;

  assign w_hold     = (r_state == PD_HOLD);
  assign word_ready = !w_hold;
  // clear wins over everything, so a word or nonce presented with it is dropped
  assign w_accept   = word_valid && !w_hold && !clear;
  assign w_nonce_wr = nonce_wr && w_hold && !clear;
  assign w_cnt_clr  = clear || (w_hold && chunks_taken);

  pd_word_counter #(
    .CNT_W     (PD_CNT_W),
    .MAX_COUNT (HDR_WORDS),
    .LAST_IDX  (HDR_WORDS - 1)
  ) u_word_counter (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_inc     (w_accept),
    .i_clr     (w_cnt_clr),
    .o_count   (w_count),
    .o_at_last (w_at_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= PD_IDLE;
      r_valid <= 1'b0;
    end else if (clear) begin
      r_state <= PD_IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        PD_IDLE: begin
          if (w_accept) r_state <= PD_LOAD;
        end
        PD_LOAD: begin
          if (w_accept && w_at_last) begin
            r_state <= PD_HOLD;
            r_valid <= 1'b1;
          end
        end
        PD_HOLD: begin
          if (chunks_taken) begin
            r_state <= PD_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= PD_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // One register per header word; word 0 lands in the most significant slot.
  genvar gi;
  generate
    for (gi = 0; gi < HDR_WORDS; gi++) begin : g_slot
      logic [WORD_W-1:0] r_word;

      assign w_slot_en[gi] = w_accept && (w_count == PD_CNT_W'(gi));

      if (gi == NONCE_IDX) begin : g_nonce
        always_ff @(posedge clk or negedge n_rst) begin
          if (!n_rst) begin
            r_word <= '0;
          end else if (w_slot_en[gi]) begin
            r_word <= word_in;
          end else if (w_nonce_wr) begin
            r_word <= nonce_in;
          end
        end
      end else begin : g_plain
        always_ff @(posedge clk or negedge n_rst) begin
          if (!n_rst) begin
            r_word <= '0;
          end else if (w_slot_en[gi]) begin
            r_word <= word_in;
          end
        end
      end

      if (gi < C1_WORDS) begin : g_c1
        assign chunk_1[C1_BITS-1-WORD_W*gi -: WORD_W] = r_word;
      end else begin : g_c2
        assign chunk_2[C2_BITS-1-WORD_W*(gi-C1_WORDS) -: WORD_W] = r_word;
      end
    end
  endgenerate

  assign chunks_valid = r_valid;
  assign word_count   = w_count;

endmodule

// File: tb/tb_pd_header_assembler.sv
// Randomised self-checking bench for pd_header_assembler against a word-array model.
module tb_pd_header_assembler;

  logic         clk;
  logic         n_rst;
  logic         clear;
  logic [31:0]  word_in;
  logic         word_valid;
  logic         word_ready;
  logic         nonce_wr;
  logic [31:0]  nonce_in;
  logic         chunks_taken;
  logic [511:0] chunk_1;
  logic [127:0] chunk_2;
  logic         chunks_valid;
  logic [4:0]   word_count;

  pd_header_assembler dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .nonce_wr     (nonce_wr),
    .nonce_in     (nonce_in),
    .chunks_taken (chunks_taken),
    .chunk_1      (chunk_1),
    .chunk_2      (chunk_2),
    .chunks_valid (chunks_valid),
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [511:0] HDR_C1 = 512'h01000000_50120119_172a610a_ddd8c2fe_1e25ea5a_2d1c5c2b_9d8c0b1e_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_efb5a4ac;
  localparam logic [127:0] HDR_C2 = 128'h4247e9f3_37221b4d_4c86041b_0f2b5710;
  localparam logic [127:0] HDR_C2_NONCE = 128'h4247e9f3_37221b4d_4c86041b_deadbeef;

  logic [31:0] hdr [20] = '{32'h01000000, 32'h50120119, 32'h172a610a, 32'hddd8c2fe,
                            32'h1e25ea5a, 32'h2d1c5c2b, 32'h9d8c0b1e, 32'h00000000,
                            32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
                            32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa, 32'hefb5a4ac,
                            32'h4247e9f3, 32'h37221b4d, 32'h4c86041b, 32'h0f2b5710};

  // Model: the header as a plain word array, how many words are in, and whether it is held.
  logic [31:0] m_words [20];
  int          m_cnt;
  bit          m_hold;
  bit          chk_en;
  int          n_vec;
  int          n_err;

  task automatic check(string name, logic [511:0] act, logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] exp_c1();
    logic [511:0] r = '0;
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = m_words[i];
    return r;
  endfunction

  function automatic logic [127:0] exp_c2();
    logic [127:0] r = '0;
    for (int i = 0; i < 4; i++) r[127-32*i -: 32] = m_words[16+i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 20; i++) m_words[i] = '0;
    m_cnt  = 0;
    m_hold = 0;
  endtask

  task automatic model_step();
    if (!n_rst) begin
      model_reset();
    end else if (clear) begin
      m_cnt  = 0;
      m_hold = 0;
    end else if (m_hold) begin
      if (nonce_wr) m_words[19] = nonce_in;
      if (chunks_taken) begin
        m_hold = 0;
        m_cnt  = 0;
      end
    end else if (word_valid) begin
      m_words[m_cnt] = word_in;
      m_cnt++;
      if (m_cnt == 20) m_hold = 1;
    end
  endtask

  // Advance one clock; the model sees exactly the inputs the DUT sampled.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("chunk_1", chunk_1, exp_c1());
      check("chunk_2", 512'(chunk_2), 512'(exp_c2()));
      check("chunks_valid", 512'(chunks_valid), 512'(m_hold));
      check("word_ready", 512'(word_ready), 512'(!m_hold));
      check("word_count", 512'(word_count), 512'(m_cnt));
    end
  end

  task automatic idle_inputs();
    word_valid   = 1'b0;
    clear        = 1'b0;
    nonce_wr     = 1'b0;
    chunks_taken = 1'b0;
  endtask

  task automatic load_words(int n, bit use_hdr);
    for (int i = 0; i < n; i++) begin
      word_valid = 1'b1;
      word_in    = use_hdr ? hdr[i] : $urandom;
      cycle();
    end
    word_valid = 1'b0;
  endtask

  logic [31:0] nonce_v;

  initial begin
    n_vec = 0;
    n_err = 0;
    chk_en = 0;
    model_reset();
    idle_inputs();
    word_in  = 32'h0;
    nonce_in = 32'h0;
    n_rst    = 1'b1;
    #2;
    n_rst      = 1'b0;
    word_valid = 1'b1;
    word_in    = 32'hcafef00d;
    chk_en     = 1;
    cycle();
    cycle();
    check("rst_chunk_1", chunk_1, 512'h0);
    check("rst_chunk_2", 512'(chunk_2), 512'h0);
    check("rst_word_ready", 512'(word_ready), 512'h1);
    check("rst_word_count", 512'(word_count), 512'h0);
    n_rst = 1'b1;
    word_valid = 1'b0;
    cycle();

    // Back-to-back load of the reference header
    load_words(20, 1);
    check("b2b_valid_edge", 512'(chunks_valid), 512'h1);
    cycle();
    check("b2b_chunk_1", chunk_1, HDR_C1);
    check("b2b_chunk_2", 512'(chunk_2), 512'(HDR_C2));
    check("b2b_valid", 512'(chunks_valid), 512'h1);
    check("b2b_ready", 512'(word_ready), 512'h0);
    chunks_taken = 1'b1;
    cycle();
    chunks_taken = 1'b0;
    check("release_count", 512'(word_count), 512'h0);
    check("release_keep_c1", chunk_1, HDR_C1);

    // Gapped load; nonce writes during the gaps must be ignored
    for (int i = 0; i < 20; i++) begin
      word_valid = 1'b0;
      nonce_wr   = 1'b1;
      nonce_in   = $urandom;
      cycle();
      check("gap_count", 512'(word_count), 512'(i));
      nonce_wr   = 1'b0;
      word_valid = 1'b1;
      word_in    = hdr[i];
      cycle();
    end
    word_valid = 1'b0;
    cycle();
    check("gap_chunk_1", chunk_1, HDR_C1);
    check("gap_chunk_2", 512'(chunk_2), 512'(HDR_C2));

    // Nonce rewrite in HOLD, then a 21st word that must bounce
    nonce_wr = 1'b1;
    nonce_in = 32'hdeadbeef;
    cycle();
    nonce_wr = 1'b0;
    check("nonce_chunk_2", 512'(chunk_2), 512'(HDR_C2_NONCE));
    check("nonce_chunk_1", chunk_1, HDR_C1);
    word_valid = 1'b1;
    word_in    = 32'h12345678;
    cycle();
    word_valid = 1'b0;
    check("w21_ready", 512'(word_ready), 512'h0);
    check("w21_chunk_2", 512'(chunk_2), 512'(HDR_C2_NONCE));
    check("w21_count", 512'(word_count), 512'd20);
    chunks_taken = 1'b1;
    cycle();
    chunks_taken = 1'b0;

    // Partial load aborted by clear, with a word presented alongside it
    load_words(7, 0);
    clear      = 1'b1;
    word_valid = 1'b1;
    word_in    = $urandom;
    cycle();
    idle_inputs();
    check("clear_count", 512'(word_count), 512'h0);
    check("clear_ready", 512'(word_ready), 512'h1);
    load_words(20, 0);
    cycle();
    nonce_v      = $urandom;
    nonce_wr     = 1'b1;
    nonce_in     = nonce_v;
    chunks_taken = 1'b1;
    cycle();
    idle_inputs();
    check("nt_nonce", 512'(chunk_2[31:0]), 512'(nonce_v));
    check("nt_valid", 512'(chunks_valid), 512'h0);

    // Asynchronous reset in the middle of a load
    load_words(12, 1);
    word_valid = 1'b1;
    word_in    = hdr[12];
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    check("arst_chunk_1", chunk_1, 512'h0);
    check("arst_chunk_2", 512'(chunk_2), 512'h0);
    check("arst_valid", 512'(chunks_valid), 512'h0);
    check("arst_count", 512'(word_count), 512'h0);
    check("arst_ready", 512'(word_ready), 512'h1);
    cycle();
    n_rst = 1'b1;
    word_valid = 1'b0;
    cycle();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      word_valid   = ($urandom_range(0, 99) < 60);
      word_in      = $urandom;
      clear        = ($urandom_range(0, 99) < 2);
      nonce_wr     = ($urandom_range(0, 99) < 15);
      nonce_in     = $urandom;
      chunks_taken = ($urandom_range(0, 99) < 10);
      cycle();
    end
    idle_inputs();
    cycle();
    chk_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
